// File: rtl/cart_pkg.sv
// cart_pkg: shared width codes, target/state enums and request record for the cart memory arbiter.
package cart_pkg;
  localparam logic [1:0] CART_W16 = 2'b10;
  localparam logic [1:0] CART_W8  = 2'b01;
  typedef enum logic {TGT_ROM, TGT_SRAM} tgt_e;
  typedef enum logic [2:0] {IDLE, ROM_WAIT, SRAM_RD, HOST_ROM, HOST_SRAM} state_e;
  typedef struct packed {
    logic        op;
    tgt_e        target;
    logic [24:0] addr;
    logic [15:0] data;
  } req_t;
endpackage

// File: rtl/cart_mem_arbiter_save_sram.sv
// save_sram: single-port byte RAM with a registered one-cycle read, read-before-write.
module save_sram #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [2**AW];
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      rdata_o <= mem_q[addr_i];
    end
  end
endmodule

// File: rtl/cart_mem_arbiter.sv
// cart_mem_arbiter: routes decoded cart requests to the ROM handshake or save SRAM,
// with a one-entry pending buffer and a host loader port served when the cart is idle.
module cart_mem_arbiter
  import cart_pkg::*;
#(
  parameter int ROM_TIMEOUT  = 64,
  parameter int ROM_WRITABLE = 0,
  parameter int SRAM_AW      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cart_rd,
  input  logic        cart_wr,
  input  logic [1:0]  cart_data_width,
  input  logic [25:0] cart_addr,
  input  logic [15:0] cart_wr_data,
  output logic [15:0] cart_rd_data,
  output logic        cart_rd_valid,
  output logic        rom_req,
  output logic        rom_we,
  output logic [24:0] rom_addr,
  output logic [15:0] rom_wdata,
  input  logic        rom_ack,
  input  logic [15:0] rom_rdata,
  input  logic        host_req,
  input  logic        host_we,
  input  logic        host_sel,
  input  logic [24:0] host_addr,
  input  logic [15:0] host_wdata,
  output logic [15:0] host_rdata,
  output logic        host_ack,
  input  logic        err_clr,
  output logic        err_drop,
  output logic        err_timeout,
  output logic        err_decode
);
  localparam int CW = $clog2(ROM_TIMEOUT + 1);
  state_e state_q, state_d;
  req_t pend_q, pend_d, cur_q, cur_d, dec_req, srv;
  logic pend_v_q, pend_v_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] rd_data_q, rd_data_d, h_rdata_q, h_rdata_d, rom_res;
  logic rd_valid_q, rd_valid_d, h_ack_q, h_ack_d;
  logic drop_q, tmo_q, dec_q;
  logic to_rom, to_sram, pulse, dec_ok, have_req, rom_busy, timeout, set_drop, set_dec;
  logic ram_en, ram_we;
  logic [SRAM_AW-1:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;

  assign pulse    = cart_rd | cart_wr;
  assign to_rom   = cart_data_width == CART_W16 && !cart_addr[25];
  assign to_sram  = cart_data_width == CART_W8 && cart_addr[25];
  assign dec_ok   = pulse && (to_rom || to_sram);
  assign set_dec  = pulse && (!(to_rom || to_sram) || (cart_rd && cart_wr));
  assign dec_req  = '{op: !cart_rd, target: tgt_e'(to_sram), addr: cart_addr[24:0], data: cart_wr_data};
  assign srv      = pend_v_q ? pend_q : dec_req;
  assign have_req = pend_v_q || dec_ok;
  assign rom_busy = state_q == ROM_WAIT || state_q == HOST_ROM;
  assign timeout  = rom_busy && !rom_ack && cnt_q == CW'(ROM_TIMEOUT - 1);
  // a timed-out read returns the GBA open-bus pattern
  assign rom_res  = rom_ack ? rom_rdata : cur_q.addr[16:1];
  assign set_drop = state_q != IDLE && dec_ok && pend_v_q;

  always_comb begin
    state_d = state_q;
    pend_d = pend_q;
    pend_v_d = pend_v_q;
    cur_d = cur_q;
    cnt_d = '0;
    rd_data_d = rd_data_q;
    rd_valid_d = 1'b0;
    h_rdata_d = h_rdata_q;
    h_ack_d = 1'b0;
    ram_en = 1'b0;
    ram_we = 1'b0;
    ram_addr = srv.addr[SRAM_AW-1:0];
    ram_wdata = srv.data[7:0];
    if (state_q != IDLE && dec_ok && !pend_v_q) begin
      pend_d = dec_req;
      pend_v_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (have_req) begin
          pend_d = dec_req;
          pend_v_d = pend_v_q && dec_ok;
          cur_d = srv;
          ram_en = srv.target == TGT_SRAM;
          ram_we = srv.op;
          state_d = srv.target == TGT_SRAM ? (srv.op ? IDLE : SRAM_RD) :
                    (!srv.op || ROM_WRITABLE != 0) ? ROM_WAIT : IDLE;
        end else if (host_req && !h_ack_q) begin
          cur_d = '{op: host_we, target: tgt_e'(host_sel), addr: host_addr, data: host_wdata};
          ram_addr = host_addr[SRAM_AW-1:0];
          ram_wdata = host_wdata[7:0];
          ram_en = host_sel;
          ram_we = host_we;
          state_d = host_sel ? HOST_SRAM : HOST_ROM;
        end
      end
      SRAM_RD: begin
        rd_valid_d = 1'b1;
        rd_data_d = {ram_rdata, ram_rdata};
        state_d = IDLE;
      end
      // the ack cycle is held here so cart pulses during it still queue behind the host
      HOST_SRAM: begin
        h_ack_d = !h_ack_q;
        h_rdata_d = h_ack_q ? h_rdata_q : {8'h00, ram_rdata};
        state_d = h_ack_q ? IDLE : HOST_SRAM;
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
        if (rom_ack || timeout) begin
          state_d = IDLE;
          cnt_d = '0;
          rd_valid_d = state_q == ROM_WAIT && !cur_q.op;
          rd_data_d = state_q == ROM_WAIT ? rom_res : rd_data_q;
          h_ack_d = state_q == HOST_ROM;
          h_rdata_d = state_q == HOST_ROM ? rom_res : h_rdata_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q <= '0;
      pend_v_q <= 1'b0;
      cur_q <= '0;
      cnt_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
      h_rdata_q <= '0;
      h_ack_q <= 1'b0;
      drop_q <= 1'b0;
      tmo_q <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      pend_v_q <= pend_v_d;
      cur_q <= cur_d;
      cnt_q <= cnt_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      h_rdata_q <= h_rdata_d;
      h_ack_q <= h_ack_d;
      drop_q <= set_drop | (drop_q & ~err_clr);
      tmo_q <= timeout | (tmo_q & ~err_clr);
      dec_q <= set_dec | (dec_q & ~err_clr);
    end
  end

  save_sram #(.AW(SRAM_AW)) u_sram (
    .clk(clk), .en_i(ram_en), .we_i(ram_we), .addr_i(ram_addr), .wdata_i(ram_wdata), .rdata_o(ram_rdata)
  );

  assign cart_rd_data  = rd_data_q;
  assign cart_rd_valid = rd_valid_q;
  assign rom_req       = rom_busy;
  assign rom_we        = rom_busy && cur_q.op && cur_q.target == TGT_ROM;
  assign rom_addr      = cur_q.addr & ~25'd1;
  assign rom_wdata     = cur_q.data;
  assign host_rdata    = h_rdata_q;
  assign host_ack      = h_ack_q;
  assign err_drop      = drop_q;
  assign err_timeout   = tmo_q;
  assign err_decode    = dec_q;
endmodule

// File: tb/tb_cart_mem_arbiter.sv
// tb_cart_mem_arbiter: scoreboard bench for cart_mem_arbiter with a small ROM backing-store responder.
module tb_cart_mem_arbiter;
  logic clk = 1'b0;
  logic rst, cart_rd, cart_wr, cart_rd_valid, rom_req, rom_we, rom_ack;
  logic host_req, host_we, host_sel, host_ack, err_clr, err_drop, err_timeout, err_decode;
  logic [1:0] cart_data_width;
  logic [25:0] cart_addr;
  logic [15:0] cart_wr_data, cart_rd_data, rom_wdata, rom_rdata, host_wdata, host_rdata;
  logic [24:0] rom_addr, host_addr;

  cart_mem_arbiter dut (
    .clk(clk), .rst(rst), .cart_rd(cart_rd), .cart_wr(cart_wr), .cart_data_width(cart_data_width),
    .cart_addr(cart_addr), .cart_wr_data(cart_wr_data), .cart_rd_data(cart_rd_data),
    .cart_rd_valid(cart_rd_valid), .rom_req(rom_req), .rom_we(rom_we), .rom_addr(rom_addr),
    .rom_wdata(rom_wdata), .rom_ack(rom_ack), .rom_rdata(rom_rdata), .host_req(host_req),
    .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack), .err_clr(err_clr), .err_drop(err_drop),
    .err_timeout(err_timeout), .err_decode(err_decode)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] data; int due;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int errors = 0, checks = 0, cyc = 0;
  int ack_delay = 5, rc = 0, episodes = 0, req_cycles = 0;
  logic model_on = 1'b0, late_ack = 1'b0, prev_req = 1'b0;
  logic [15:0] ack_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM backing store: acks on the ack_delay-th cycle of a request episode
  initial begin
    rom_ack = 1'b0;
    rom_rdata = '0;
    forever begin
      @(negedge clk);
      rom_ack = 1'b0;
      if (rom_req && !prev_req) episodes++;
      if (rom_req) req_cycles++;
      prev_req = rom_req;
      rc = rom_req ? rc + 1 : 0;
      if (model_on && rc == ack_delay) begin
        rom_ack = 1'b1;
        rom_rdata = ack_data;
      end
      if (late_ack) begin
        rom_ack = 1'b1;
        rom_rdata = 16'hDEAD;
        late_ack = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && cart_rd_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: cart_rd_valid with data %h at cycle %0d, none expected", cart_rd_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (cart_rd_data !== mon_e.data || cyc != mon_e.due) begin
          errors++;
          $display("FAIL rd_data: got %h at cycle %0d, expected %h at cycle %0d", cart_rd_data, cyc, mon_e.data, mon_e.due);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic rd, input logic wr, input logic [1:0] w, input logic [25:0] a, input logic [15:0] d);
    cart_rd = rd;
    cart_wr = wr;
    cart_data_width = w;
    cart_addr = a;
    cart_wr_data = d;
    step();
    cart_rd = 1'b0;
    cart_wr = 1'b0;
    cart_data_width = 2'b00;
  endtask

  task automatic wait_drain(input int max, input string name);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d reads outstanding after %0d cycles, expected 0", name, sb.size(), max);
      sb.delete();
    end
    step();
  endtask

  task automatic host_txn(input logic sel, input logic we, input logic [24:0] a, input logic [15:0] d, output logic [15:0] rd);
    int n = 0;
    host_req = 1'b1;
    host_sel = sel;
    host_we = we;
    host_addr = a;
    host_wdata = d;
    do begin
      @(negedge clk);
      n++;
    end while (host_ack !== 1'b1 && n < 100);
    rd = host_rdata;
    checks++;
    if (host_ack !== 1'b1) begin
      errors++;
      $display("FAIL host_ack: no ack within %0d cycles, expected 1", n);
    end
    step();
    host_req = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cart_rd_data, cart_rd_valid, rom_req, rom_we, rom_addr, rom_wdata, host_rdata, host_ack,
         err_drop, err_timeout, err_decode} !== 80'd0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero (rd_data=%h req=%b addr=%h), expected all 0", cart_rd_data, rom_req, rom_addr);
    end
    step();
  endtask

  task automatic test_sram();
    pulse(1'b0, 1'b1, 2'b01, 26'h2000010, 16'h00A5);
    pulse(1'b0, 1'b1, 2'b01, 26'h200FFFF, 16'h123C);
    sb.push_back('{16'hA5A5, cyc + 2});
    pulse(1'b1, 1'b0, 2'b01, 26'h2000010, 16'h0000);
    wait_drain(6, "sram_rd");
    sb.push_back('{16'h3C3C, cyc + 2});
    pulse(1'b1, 1'b0, 2'b01, 26'h200FFFF, 16'h0000);
    wait_drain(6, "sram_rd_top");
    check_bit("sram_no_decode_err", err_decode, 1'b0);
  endtask

  task automatic test_rom_read();
    int ep0 = episodes;
    model_on = 1'b1;
    ack_delay = 5;
    ack_data = 16'hBEEF;
    sb.push_back('{16'hBEEF, cyc + 6});
    pulse(1'b1, 1'b0, 2'b10, 26'h0000124, 16'h0000);
    @(negedge clk);
    check_bit("rom_req_after_pulse", rom_req, 1'b1);
    check_word("rom_addr", {7'd0, rom_addr}, 32'h0000124);
    check_bit("rom_we_read", rom_we, 1'b0);
    wait_drain(12, "rom_rd");
    check_word("rom_episodes", episodes - ep0, 1);
    check_bit("rom_req_dropped", rom_req, 1'b0);
    model_on = 1'b0;
  endtask

  task automatic test_timeout();
    int rq0 = req_cycles;
    sb.push_back('{16'h0123, cyc + 65});
    pulse(1'b1, 1'b0, 2'b10, 26'h0000246, 16'h0000);
    wait_drain(80, "rom_timeout");
    check_word("timeout_req_cycles", req_cycles - rq0, 64);
    check_bit("timeout_req_low", rom_req, 1'b0);
    check_bit("err_timeout_set", err_timeout, 1'b1);
    repeat (3) step();
    check_bit("err_timeout_sticky", err_timeout, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    check_bit("err_timeout_cleared", err_timeout, 1'b0);
    step();
  endtask

  task automatic test_contention();
    logic [15:0] r;
    host_req = 1'b1;
    host_we = 1'b1;
    host_sel = 1'b1;
    host_addr = 25'h0000020;
    host_wdata = 16'h005A;
    step();
    sb.push_back('{16'hA5A5, cyc + 4});
    pulse(1'b1, 1'b0, 2'b01, 26'h2000010, 16'h0000);
    cart_rd = 1'b1;
    cart_data_width = 2'b01;
    cart_addr = 26'h2000020;
    @(negedge clk);
    check_bit("host_ack_contention", host_ack, 1'b1);
    step();
    cart_rd = 1'b0;
    cart_data_width = 2'b00;
    host_req = 1'b0;
    @(negedge clk);
    check_bit("err_drop_set", err_drop, 1'b1);
    wait_drain(6, "contention_rd");
    host_txn(1'b1, 1'b0, 25'h0000020, 16'h0000, r);
    check_word("host_sram_rdata", {16'd0, r}, 32'h005A);
    model_on = 1'b1;
    ack_delay = 3;
    ack_data = 16'h7777;
    host_txn(1'b0, 1'b0, 25'h0000ABC, 16'h0000, r);
    check_word("host_rom_rdata", {16'd0, r}, 32'h7777);
    model_on = 1'b0;
    step();
  endtask

  task automatic test_decode();
    logic [15:0] r;
    int ep0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    ep0 = episodes;
    pulse(1'b1, 1'b0, 2'b01, 26'h0000300, 16'h0000);
    @(negedge clk);
    check_bit("err_decode_set", err_decode, 1'b1);
    step();
    pulse(1'b0, 1'b1, 2'b10, 26'h0000400, 16'h1111);
    repeat (4) step();
    check_word("decode_no_rom_req", episodes - ep0, 0);
    cart_rd = 1'b1;
    err_clr = 1'b1;
    step();
    cart_rd = 1'b0;
    err_clr = 1'b0;
    @(negedge clk);
    check_bit("err_set_beats_clr", err_decode, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    check_bit("err_decode_cleared", err_decode, 1'b0);
    step();
    sb.push_back('{16'hA5A5, cyc + 2});
    pulse(1'b1, 1'b1, 2'b01, 26'h2000010, 16'h0077);
    @(negedge clk);
    check_bit("rd_wr_decode_err", err_decode, 1'b1);
    wait_drain(6, "rd_wins");
    host_txn(1'b1, 1'b0, 25'h0000010, 16'h0000, r);
    check_word("rd_wins_no_write", {16'd0, r}, 32'h00A5);
    step();
  endtask

  task automatic test_reset_mid();
    int ep0 = episodes;
    pulse(1'b1, 1'b0, 2'b10, 26'h0000500, 16'h0000);
    @(negedge clk);
    check_bit("mid_rom_req", rom_req, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cart_rd_data, cart_rd_valid, rom_req, rom_we, rom_addr, rom_wdata, host_rdata, host_ack,
         err_drop, err_timeout, err_decode} !== 80'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got nonzero (req=%b addr=%h), expected all 0", rom_req, rom_addr);
    end
    late_ack = 1'b1;
    repeat (5) step();
    check_bit("late_ack_no_req", rom_req, 1'b0);
    check_word("late_ack_episodes", episodes - ep0, 1);
  endtask

  initial begin
    rst = 1'b1;
    cart_rd = 1'b0;
    cart_wr = 1'b0;
    cart_data_width = 2'b00;
    cart_addr = '0;
    cart_wr_data = '0;
    host_req = 1'b0;
    host_we = 1'b0;
    host_sel = 1'b0;
    host_addr = '0;
    host_wdata = '0;
    err_clr = 1'b0;
    test_reset();
    test_sram();
    test_rom_read();
    test_timeout();
    test_contention();
    test_decode();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: %0d reads never returned, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cart_mem_arbiter.md
Name: cart_mem_arbiter

Overview:
- Sits directly downstream of the GBA cartridge bus front end and consumes its decoded request stream: single-cycle rd/wr pulses, 26-bit tagged address, width code.
- Routes ROM accesses (addr[25]=0) to an external ROM backing-store handshake port.
- Routes save-SRAM accesses (addr[25]=1) to an internal 64 KiB byte RAM.
- Returns read data with a one-cycle valid strobe, and lets a host loader port access both stores whenever the cart side is idle.

Parameters:
- ROM_TIMEOUT, 64: cycles to wait for rom_ack before an open-bus response.
- ROM_WRITABLE, 0: 1 forwards cart ROM writes to the backing store; 0 drops them silently.
- SRAM_AW, 16: save-SRAM byte address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cart_rd  in  1  one-cycle read request pulse
- cart_wr  in  1  one-cycle write request pulse
- cart_data_width  in  2  2'b10 = 16-bit ROM, 2'b01 = 8-bit SRAM, 2'b00 = none
- cart_addr  in  26  bit25 = SRAM select; ROM uses [24:0] byte address, SRAM uses [SRAM_AW-1:0]
- cart_wr_data  in  16  write data; SRAM uses [7:0]
- cart_rd_data  out  16  read data
- cart_rd_valid  out  1  one-cycle read-data strobe
- rom_req  out  1  ROM request, held until rom_ack
- rom_we  out  1  ROM write qualifier
- rom_addr  out  25  ROM byte address, bit0 = 0
- rom_wdata  out  16  ROM write data
- rom_ack  in  1  ROM completion, one cycle
- rom_rdata  in  16  ROM read data, valid with rom_ack
- host_req  in  1  host request, held until host_ack
- host_we  in  1  host write qualifier
- host_sel  in  1  host target: 0 = ROM, 1 = SRAM
- host_addr  in  25  host address
- host_wdata  in  16  host write data
- host_rdata  out  16  host read data, valid with host_ack
- host_ack  out  1  host completion, one cycle
- err_clr  in  1  clears all sticky error flags
- err_drop  out  1  sticky: cart request dropped
- err_timeout  out  1  sticky: ROM timeout
- err_decode  out  1  sticky: width/address mismatch

Behaviour:
- Reset: all outputs 0; FSM to IDLE; pending buffer empty; SRAM contents not cleared.
- Decode (same cycle as pulse):
  - width 2'b10 with addr[25]=0 → ROM.
  - width 2'b01 with addr[25]=1 → SRAM.
  - Any other combination → ignored, err_decode set.
  - cart_rd and cart_wr high in the same cycle → read wins, err_decode set.
- One-entry pending buffer captures every decoded cart request: op, target, addr, data.
- FSM states: IDLE, ROM_WAIT, SRAM_RD, HOST_ROM, HOST_SRAM.
- IDLE priority: pending cart request > incoming cart pulse > host_req.
  - A cart pulse in IDLE is served that cycle without occupying the buffer.
- Arbitration: a host transaction is never preempted; cart requests arriving during it queue in the buffer.
- Overflow: a cart pulse arriving while the buffer is already full is dropped and err_drop is set; the buffered request is kept.
- SRAM read:
  - Pulse at cycle N → BRAM read issued at N → cart_rd_valid at N+2.
  - cart_rd_data = {byte, byte}.
- SRAM write: completes in 1 cycle; no valid strobe.
- ROM read:
  - rom_req asserted the cycle after the pulse; rom_addr = {addr[24:1], 1'b0}.
  - rom_ack at cycle M → cart_rd_valid at M+1 with the registered rom_rdata.
  - rom_req drops the cycle after rom_ack.
- ROM write:
  - ROM_WRITABLE=1: same handshake with rom_we=1.
  - ROM_WRITABLE=0: no rom_req, back to IDLE immediately.
- ROM timeout: the counter counts cycles in ROM_WAIT. When it reaches ROM_TIMEOUT:
  - rom_req deasserts and err_timeout is set.
  - For a read, cart_rd_valid pulses with cart_rd_data = addr[16:1] (GBA open-bus value).
- Late acks: a rom_ack arriving outside ROM_WAIT is ignored.
- Host:
  - Same timing as cart transactions.
  - host_ack pulses once per transaction; host_rdata is valid with it.
  - host_sel=1 uses host_addr[SRAM_AW-1:0] and wdata[7:0], and returns {8'h00, byte}.
- Sticky flags: err_clr clears all flags; a flag-setting event in the same cycle takes priority.
- Reset mid-transaction: rom_req drops next cycle, no valid/ack is emitted, and the pending request is discarded.

Decomposition:
- Package cart_pkg holds:
  - width codes CART_W16 = 2'b10, CART_W8 = 2'b01;
  - the target enum {TGT_ROM, TGT_SRAM};
  - the FSM state enum;
  - the request struct {op, target, addr, data}.
- Sub-module save_sram: single-port byte RAM, 2**SRAM_AW deep, synchronous 1-cycle read, write-enable, inferred BRAM.

Test Plan:
- SRAM write then read: cart_wr to addr 26'h2000010, data 16'h00A5; cart_rd to the same address → cart_rd_valid exactly 2 cycles after the pulse with 16'hA5A5.
- ROM read: cart_rd to 26'h0000124, width 2'b10; model acks after 5 cycles with 16'hBEEF → rom_addr 25'h0000124, cart_rd_valid 1 cycle after ack with 16'hBEEF, single rom_req episode.
- ROM timeout: no ack, ROM_TIMEOUT=64, read of addr 26'h0000246 → valid at timeout with data 16'h0123; err_timeout=1 until err_clr.
- Contention: host SRAM write in progress, then two cart pulses → first served after host_ack, second dropped, err_drop=1.
- Decode error: width 2'b01 with addr[25]=0 → no rom_req, no valid, err_decode=1.
- Reset mid-ROM_WAIT: assert rst during rom_req → all outputs 0 next cycle; a late rom_ack produces no cart_rd_valid.
